gpu_scan_timing: RTL and testbench

- Generates the raster scan that drives the GPU's pixel-layer modules (grid, trace, text). Each layer takes a 10-bit row/col and returns a combinational hit flag.
- This block holds horizontal/vertical counters and presents row/col to all layers in parallel. It also produces VGA hsync/vsync and data-enable.
- It delays sync/DE through a configurable pipeline, so they line up with the registered layer-composite path downstream.
- Default timing is SVGA 800x600@60 (40 MHz pixel rate).

---
 rtl/gpu_scan_timing.sv | 153 +++++++++++++++
 tb/tb_gpu_scan_timing.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gpu_scan_timing.sv
// Raster scan generator: pixel/line counters, visible-region coordinates,
// line/frame pulses and polarity-configurable syncs with a pipelined delay.
module gpu_scan_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = (H_POL != 0);
  localparam logic        VS_ON    = (V_POL != 0);

  // Coordinates are 10 bits and counters 11 bits; anything wider cannot be represented.
  if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_chk_active
    $error("gpu_scan_timing: H_ACTIVE/V_ACTIVE must be <= 1024");
  end
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_chk_total
    $error("gpu_scan_timing: H_TOTAL/V_TOTAL must be <= 2047");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_chk_lat
    $error("gpu_scan_timing: PIPE_LAT must be in 0..7");
  end

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [9:0]  r_row;
  logic [9:0]  r_col;
  logic        r_active;
  logic        r_line_start;
  logic        r_frame_start;
  logic        r_hsync;
  logic        r_vsync;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_vis;
  logic w_hs;
  logic w_vs;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_vis    = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign w_hs     = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign w_vs     = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

  // Horizontal and vertical position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else if (pix_ce) begin
      if (w_h_wrap) begin
        r_h_cnt <= 11'd0;
        r_v_cnt <= w_v_wrap ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  // Decode of the pixel the counters hold at this edge; pulses drop when pix_ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row         <= 10'd0;
      r_col         <= 10'd0;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
    end else if (pix_ce) begin
      r_row         <= w_vis ? r_v_cnt[9:0] : 10'd0;
      r_col         <= w_vis ? r_h_cnt[9:0] : 10'd0;
      r_active      <= w_vis;
      r_line_start  <= w_vis && (r_h_cnt == 11'd0);
      r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
      r_hsync       <= w_hs ? HS_ON : ~HS_ON;
      r_vsync       <= w_vs ? VS_ON : ~VS_ON;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign row         = r_row;
  assign col         = r_col;
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

  if (PIPE_LAT == 0) begin : g_nopipe
    assign hsync_out = r_hsync;
    assign vsync_out = r_vsync;
    assign de_out    = r_active;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] r_hs_pipe;
    logic [PIPE_LAT-1:0] r_vs_pipe;
    logic [PIPE_LAT-1:0] r_de_pipe;

    // Delay line matching the downstream registered layer-composite latency.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hs_pipe <= {PIPE_LAT{~HS_ON}};
        r_vs_pipe <= {PIPE_LAT{~VS_ON}};
        r_de_pipe <= {PIPE_LAT{1'b0}};
      end else if (pix_ce) begin
        r_hs_pipe[0] <= r_hsync;
        r_vs_pipe[0] <= r_vsync;
        r_de_pipe[0] <= r_active;
        for (int i = 1; i < PIPE_LAT; i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
          r_de_pipe[i] <= r_de_pipe[i-1];
        end
      end
    end

    assign hsync_out = r_hs_pipe[PIPE_LAT-1];
    assign vsync_out = r_vs_pipe[PIPE_LAT-1];
    assign de_out    = r_de_pipe[PIPE_LAT-1];
  end

endmodule

// File: tb/tb_gpu_scan_timing.sv
// Bench for gpu_scan_timing: a reduced-timing instance (inverted hsync, 3-deep
// delay) and a default SVGA instance (no delay), both checked against a pixel-index model.
module tb_gpu_scan_timing;

  localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 3;
  localparam int SHP = 0, SVP = 1, SLAT = 3;
  localparam int DHA = 800, DHF = 40, DHS = 128, DHB = 88;
  localparam int DVA = 600, DVF = 1, DVS = 4, DVB = 23;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       act;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [9:0] s_row, s_col, d_row, d_col;
  logic       s_act, s_ls, s_fs, s_hs, s_vs, s_de;
  logic       d_act, d_ls, d_fs, d_hs, d_vs, d_de;

  longint n;        // pix_ce edges seen since the last reset
  bit     last_ce;  // pix_ce value consumed by the most recent edge
  bit     directed;
  int     checks = 0;
  int     errors = 0;

  gpu_scan_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_POL(SHP), .V_POL(SVP), .PIPE_LAT(SLAT)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .row(s_row), .col(s_col), .active(s_act),
    .line_start(s_ls), .frame_start(s_fs),
    .hsync_out(s_hs), .vsync_out(s_vs), .de_out(s_de)
  );

  gpu_scan_timing #(.PIPE_LAT(0)) u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .row(d_row), .col(d_col), .active(d_act),
    .line_start(d_ls), .frame_start(d_fs),
    .hsync_out(d_hs), .vsync_out(d_vs), .de_out(d_de)
  );

  initial forever #5 clk = ~clk;

  // Outputs after nn edges show pixel nn-1 of the raster; delayed outputs show pixel nn-1-lat.
  function automatic exp_t model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                 input int hp, vp, lat, input longint nn, input bit ce);
    exp_t   e;
    longint ht, tot, p, m;
    int     h, v;
    ht    = longint'(ha + hf + hs + hb);
    tot   = ht * longint'(va + vf + vs + vb);
    e     = '0;
    e.hs  = (hp == 0);
    e.vs  = (vp == 0);
    if (nn > 0) begin
      p = (nn - 1) % tot;
      h = int'(p % ht);
      v = int'(p / ht);
      if (h < ha && v < va) begin
        e.row = 10'(v);
        e.col = 10'(h);
        e.act = 1'b1;
        e.ls  = ce && (h == 0);
      end
      e.fs = ce && (h == 0) && (v == 0);
    end
    m = nn - 1 - longint'(lat);
    if (m >= 0) begin
      p    = m % tot;
      h    = int'(p % ht);
      v    = int'(p / ht);
      e.de = (h < ha) && (v < va);
      if (h >= ha + hf && h < ha + hf + hs) e.hs = (hp != 0);
      if (v >= va + vf && v < va + vf + vs) e.vs = (vp != 0);
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got=%h want=%h (row,col,act,ls,fs,hs,vs,de)", nm, n, got, want);
    end
  endtask

  task automatic pin(input string nm, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got=%0d want=%0d", nm, n, got, want);
    end
  endtask

  task automatic check_all();
    cmp("small", {s_row, s_col, s_act, s_ls, s_fs, s_hs, s_vs, s_de},
        model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SHP, SVP, SLAT, n, last_ce));
    cmp("dflt", {d_row, d_col, d_act, d_ls, d_fs, d_hs, d_vs, d_de},
        model(DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1, 1, 0, n, last_ce));
  endtask

  // Hand-computed values that pin the model during the constant pix_ce phase.
  task automatic check_pins();
    if (directed && last_ce) begin
      case (n)
        64'd1: begin
          pin("first_fs", 10'(s_fs), 10'd1);
          pin("first_ls", 10'(s_ls), 10'd1);
          pin("first_dfs", 10'(d_fs), 10'd1);
        end
        64'd3:   pin("de_lat_lo", 10'(s_de), 10'd0);
        64'd4:   pin("de_lat_hi", 10'(s_de), 10'd1);
        64'd21: begin
          pin("hblank_act", 10'(s_act), 10'd0);
          pin("hblank_col", s_col, 10'd0);
        end
        64'd26:  pin("hs_lo_pre", 10'(s_hs), 10'd1);
        64'd27:  pin("hs_lo_on", 10'(s_hs), 10'd0);
        64'd34: begin
          pin("line1_row", s_row, 10'd1);
          pin("line1_col", s_col, 10'd1);
        end
        64'd251: pin("dflt_col250", d_col, 10'd250);
        64'd840: pin("dflt_hs_pre", 10'(d_hs), 10'd0);
        64'd841: pin("dflt_hs_on", 10'(d_hs), 10'd1);
        default: ;
      endcase
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 n = 0;
    last_ce = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  // mode 0: pix_ce held high, 1: alternating, 2: random with occasional resets
  task automatic run(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (last_ce) n++;
      check_all();
      check_pins();
      if (mode == 2 && $urandom_range(0, 4999) == 0) async_reset();
      case (mode)
        0:       pix_ce = 1'b1;
        1:       pix_ce = ~pix_ce;
        default: pix_ce = ($urandom_range(0, 3) != 0);
      endcase
      last_ce = pix_ce;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pix_ce   = 1'b0;
    n        = 0;
    last_ce  = 1'b0;
    directed = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n    = 1'b1;
    pix_ce   = 1'b1;
    last_ce  = 1'b1;
    directed = 1'b1;
    run(1200, 0);
    directed = 1'b0;
    async_reset();
    pix_ce  = 1'b1;
    last_ce = 1'b1;
    run(2400, 1);
    run(20000, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
